// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multi-cycle multiply/divide unit owning HI/LO
//
// Purpose:
//   Executes mult/multu/div/divu over MULT_CYCLES/DIV_CYCLES cycles and
//   mthi/mtlo in a single cycle. Provides mfhi/mflo read data and a stall
//   request that holds a D-stage MDU instruction while an operation is pending.
//   Optional feature macro: MDU_FAST_MULT_EN (mult/multu complete on the start
//   edge and never occupy the BUSY state).
//
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous active-low reset
//   int_req   in   1   E-stage instruction is being flushed this cycle
//   op        in   4   MDU op code (0 NONE .. 8 MTLO, 9-15 NONE)
//   A, B      in   32  forwarded rs/rt operands
//   d_is_md   in   1   D-stage instruction is an MDU op
//   busy      out  1   operation in flight
//   md_stall  out  1   stall request to the hazard unit
//   HI, LO    out  32  architectural HI/LO registers
//   MDU_out   out  32  mfhi/mflo read data, 0 for any other op

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_N + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

`ifdef MDU_FAST_MULT_EN
  localparam bit FAST_MULT = 1'b1;
`else
  localparam bit FAST_MULT = 1'b0;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;

  logic is_mult, is_div, can_issue, slow_start, fast_start;

  assign is_mult    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
  assign can_issue  = (state == IDLE) && !int_req;
  // Only operations that enter BUSY count as a start for stalling purposes.
  assign slow_start = can_issue && (is_div || (is_mult && !FAST_MULT));
  assign fast_start = can_issue && is_mult && FAST_MULT;

  assign busy     = (state == BUSY);
  assign md_stall = d_is_md && (busy || slow_start);

  // Arithmetic. Divisors are forced to 1 when zero so no X is ever produced;
  // the zero-divisor case suppresses the HI/LO write via res_wr instead.
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, mag_b, q_mag, r_mag, s_quo, s_rem;
  logic [31:0] ub, u_quo, u_rem;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  assign abs_a  = A[31] ? (~A + 32'd1) : A;
  assign abs_b  = B[31] ? (~B + 32'd1) : B;
  assign mag_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign q_mag  = abs_a / mag_b;
  assign r_mag  = abs_a % mag_b;
  assign s_quo  = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign s_rem  = A[31] ? (~r_mag + 32'd1) : r_mag;

  assign ub     = (B == 32'd0) ? 32'd1 : B;
  assign u_quo  = A / ub;
  assign u_rem  = A % ub;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (B == 32'd0) begin
          res_wr = 1'b0;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = s_rem;
          res_lo = s_quo;
        end
      end
      OP_DIVU: begin
        if (B == 32'd0) begin
          res_wr = 1'b0;
        end else begin
          res_hi = u_rem;
          res_lo = u_quo;
        end
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (slow_start) next_state = BUSY;
      BUSY: if (cnt == CW'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (state == IDLE) begin
      if (slow_start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
        cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (fast_start) begin
        HI <= res_hi;
        LO <= res_lo;
      end else if (can_issue && op == OP_MTHI) begin
        HI <= A;
      end else if (can_issue && op == OP_MTLO) begin
        LO <= A;
      end
    end else begin
      // BUSY: ops in E are ignored; the operation finishes regardless of int_req.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end
  end

  always_comb begin
    MDU_out = 32'd0;
    if (op == OP_MFHI)      MDU_out = HI;
    else if (op == OP_MFLO) MDU_out = LO;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed self-checking bench for e_mdu (default build)

module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        d_is_md;
  logic        busy, md_stall;
  logic [31:0] hi, lo, mdu_out;

  int errors = 0;
  int checks = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .int_req (int_req),
    .op      (op),
    .A       (a),
    .B       (b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .md_stall(md_stall),
    .HI      (hi),
    .LO      (lo),
    .MDU_out (mdu_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for one edge, then count busy cycles (bounded).
  task automatic run_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
    op = o; a = x; b = y;
    step();
    op = 4'd0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; int_req = 1'b0; op = 4'd0; a = 0; b = 0; d_is_md = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  task automatic test_mthi_mtlo();
    op = 4'd7; a = 32'h1234; int_req = 1'b1;
    step();
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mthi_flushed got=%h exp=0", hi); end
    int_req = 1'b0;
    step();
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got=%h exp=1234", hi); end
    op = 4'd5; #1;
    checks++; if (mdu_out !== 32'h1234) begin errors++; $display("FAIL mfhi got=%h exp=1234", mdu_out); end
    op = 4'd8; a = 32'h55AA;
    step();
    op = 4'd6; #1;
    checks++; if (mdu_out !== 32'h55AA) begin errors++; $display("FAIL mflo got=%h exp=55aa", mdu_out); end
    op = 4'd9; a = 32'hDEAD;
    #1;
    checks++; if (mdu_out !== 32'd0) begin errors++; $display("FAIL mdu_out_none got=%h exp=0", mdu_out); end
    step();
    checks++; if (hi !== 32'h1234 || lo !== 32'h55AA || busy !== 1'b0) begin
      errors++; $display("FAIL op9_nochange got=%h/%h/%0b exp=1234/55aa/0", hi, lo, busy);
    end
    op = 4'd0;
  endtask

  task automatic test_mult();
    int n;
    run_md(4'd1, 32'hFFFF_FFFE, 32'd3, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult got=%h_%h exp=ffffffff_fffffffa", hi, lo);
    end
    run_md(4'd2, 32'hFFFF_FFFE, 32'd3, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL multu got=%h_%h exp=00000002_fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div got=hi %h lo %h exp=hi ffffffff lo fffffffd", hi, lo);
    end
    run_md(4'd4, 32'd7, 32'd0, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divu0_busy got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divu0_keep got=hi %h lo %h exp=hi ffffffff lo fffffffd", hi, lo);
    end
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++; $display("FAIL div_ovf got=hi %h lo %h exp=hi 0 lo 80000000", hi, lo);
    end
    run_md(4'd4, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin
      errors++; $display("FAIL divu got=hi %h lo %h exp=hi 1 lo 7ffffffc", hi, lo);
    end
  endtask

  task automatic test_stall();
    int n;
    int bad;
    d_is_md = 1'b1; op = 4'd1; a = 32'd6; b = 32'd7;
    #1;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_start got=%0b exp=1", md_stall); end
    step();
    op = 4'd0;
    n = 0; bad = 0;
    while (busy && n < 50) begin
      if (md_stall !== 1'b1) bad++;
      n++;
      step();
    end
    checks++; if (bad !== 0 || n !== 5) begin
      errors++; $display("FAIL stall_busy got=%0d low cycles of %0d exp=0 of 5", bad, n);
    end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%0b exp=0", md_stall); end
    checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL stall_mult got=%h_%h exp=0_2a", hi, lo); end
    d_is_md = 1'b0;
  endtask

  task automatic test_int_and_reset();
    int n;
    op = 4'd3; a = 32'd100; b = 32'd7;
    step();
    op = 4'd0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      int_req = (n == 3);
      step();
    end
    int_req = 1'b0;
    checks++; if (n !== 10) begin errors++; $display("FAIL int_busy got=%0d exp=10", n); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL int_div got=hi %h lo %h exp=hi 2 lo e", hi, lo);
    end
    op = 4'd4; a = 32'd9; b = 32'd2;
    step();
    op = 4'd0;
    for (int i = 0; i < 5; i++) step();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL async_reset got=%0b/%h/%h exp=0/0/0", busy, hi, lo);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_discard got=%0b/%h/%h exp=0/0/0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_stall();
    test_int_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
